fifo_uart_tx: RTL and testbench

- Downstream drain stage for the 4-entry byte FIFO.
- Pops one byte at a time through the FIFO read handshake (rd_en / empty / registered data_out) and serializes it onto a single-wire asynchronous line: start bit, 8 data bits LSB first, stop bit.
- Sits between the FIFO and the chip-level TX pin.
- Never reads when the FIFO reports empty.

---
 rtl/fifo_uart_tx.sv | 154 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and serializes each as start bit,
// DATA_W data bits LSB first, stop bit on an idle-high line.
// Optional even-parity bit between data and stop: define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_W - 1);

  // A line bit must span at least two clocks so done can be raised a cycle early.
  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              par_q;
`endif

  // Frame sequencer: pop handshake, line bit timing and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      fifo_rd_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_en && !fifo_empty) begin
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          state <= LOAD;
        end
        LOAD: begin
          // FIFO data_out is valid now, one cycle after the pop pulse.
          shift   <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          par_q   <= ^fifo_data;
`endif
          clk_cnt <= '0;
          bit_cnt <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= par_q;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          // Raised one cycle ahead so the registered pulse lands on the last stop cycle.
          if (clk_cnt == CNT_PRE_LAST) begin
            done <= 1'b1;
          end
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized and directed bench for fifo_uart_tx against a
// frame-timeline reference model and a simple byte FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB  = 4;
  localparam int DW   = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam int HIST  = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_en = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en, tx, busy, done;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // FIFO model: bench writes push_mem/push_wr, FIFO process owns pop_rd.
  logic [7:0] push_mem [1024];
  int         push_wr = 0;
  int         pop_rd  = 0;
  assign fifo_empty = (push_wr == pop_rd);

  logic tx_hist [HIST];
  int   rd_log[$];
  int   done_log[$];

  // Reference model: position within the current frame timeline.
  bit         m_act  = 1'b0;
  int         m_off  = 0;
  logic [7:0] m_byte = '0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // FIFO read port: registered data_out one cycle after the pop.
  always @(posedge clk) begin
    if (fifo_rd_en && (push_wr != pop_rd)) begin
      fifo_data <= push_mem[pop_rd % 1024];
      pop_rd    <= pop_rd + 1;
    end
  end

  // Frame timeline: offset 0 = pop cycle, 1 = load, 2.. = line bits, FRAME+1 = last stop cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0;
      m_off = 0;
    end else if (!m_act) begin
      if (tx_en && !fifo_empty) begin
        m_act  = 1'b1;
        m_off  = 0;
        m_byte = push_mem[pop_rd % 1024];
      end
    end else if (m_off == FRAME + 1) begin
      m_act = 1'b0;
    end else begin
      m_off++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
    logic [NBITS-1:0] v;
    v       = '1;
    v[0]    = 1'b0;
    v[DW:1] = b;
`ifdef FIFO_UART_TX_PARITY_EN
    v[DW+1] = ^b;
`endif
    return v;
  endfunction

  // Per-cycle sampling (at negedge) against the reference model.
  task automatic sample();
    logic [NBITS-1:0] v;
    logic e_tx, e_rd, e_busy, e_done;
    cyc++;
    if (cyc < HIST) tx_hist[cyc] = tx;
    if (fifo_rd_en) rd_log.push_back(cyc);
    if (done) done_log.push_back(cyc);
    if (m_act) begin
      v      = frame_bits(m_byte);
      e_tx   = (m_off < 2) ? 1'b1 : v[(m_off - 2) / CPB];
      e_rd   = (m_off == 0);
      e_busy = 1'b1;
      e_done = (m_off == FRAME + 1);
    end else begin
      e_tx   = 1'b1;
      e_rd   = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
    end
    check("line_tx", 32'(tx), 32'(e_tx));
    check("rd_en", 32'(fifo_rd_en), 32'(e_rd));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("tx_known", 32'($isunknown(tx)), 32'(0));
    check("rd_when_empty", 32'(fifo_rd_en & fifo_empty), 32'(0));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_mem[push_wr % 1024] = b;
    push_wr++;
  endtask

  task automatic wait_rd(input int n, input string tag);
    int i;
    i = 0;
    while (rd_log.size() < n && i < 500) begin
      tick(1);
      i++;
    end
    check(tag, 32'(rd_log.size() >= n), 32'(1));
  endtask

  task automatic wait_done(input int n, input string tag);
    int i;
    i = 0;
    while (done_log.size() < n && i < 500) begin
      tick(1);
      i++;
    end
    check(tag, 32'(done_log.size() >= n), 32'(1));
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input int start);
    logic [NBITS-1:0] v;
    v = frame_bits(b);
    for (int j = 0; j < FRAME; j++) begin
      if (start + j > 0 && start + j < HIST)
        check(tag, 32'(tx_hist[start + j]), 32'(v[j / CPB]));
    end
  endtask

  initial begin
    int r;
    int t0;
    int i;

    // Reset with FIFO empty and tx_en high: must stay idle.
    tick(2);
    rst = 1'b0;
    tick(20);
    check("empty_no_pop", 32'(rd_log.size()), 32'(0));
    check("empty_busy", 32'(busy), 32'(0));
    check("empty_tx", 32'(tx), 32'(1));

    // Single frame 8'hA5.
    rd_log.delete();
    done_log.delete();
    push(8'hA5);
    wait_done(1, "a5_wait");
    tick(5);
    r = rd_log[0];
    check("a5_rd_cnt", 32'(rd_log.size()), 32'(1));
    check("a5_load_high", 32'(tx_hist[r + 1]), 32'(1));
    check("a5_start_at_t2", 32'(tx_hist[r + 2]), 32'(0));
    check("a5_done_cnt", 32'(done_log.size()), 32'(1));
    check("a5_done_pos", 32'(done_log[0] - (r + 2) + 1), 32'(FRAME));
    check_frame("a5_line", 8'hA5, r + 2);

    // Back-to-back frames 8'h01 then 8'hFF.
    rd_log.delete();
    done_log.delete();
    push(8'h01);
    push(8'hFF);
    wait_done(2, "b2b_wait");
    tick(5);
    check("b2b_rd_cnt", 32'(rd_log.size()), 32'(2));
    check("b2b_gap", 32'((rd_log[1] + 2) - done_log[0] - 1), 32'(3));
    for (int k = 1; k <= 3; k++)
      check("b2b_gap_high", 32'(tx_hist[done_log[0] + k]), 32'(1));
    check_frame("b2b_f1", 8'h01, rd_log[0] + 2);
    check_frame("b2b_f2", 8'hFF, rd_log[1] + 2);

    // tx_en gating and mid-frame deassertion.
    rd_log.delete();
    done_log.delete();
    tx_en = 1'b0;
    push(8'h5A);
    tick(20);
    check("dis_no_rd", 32'(rd_log.size()), 32'(0));
    t0 = cyc;
    tx_en = 1'b1;
    wait_rd(1, "en_wait");
    check("en_rd_lat", 32'(rd_log[0] - t0), 32'(1));
    i = 0;
    while (cyc < rd_log[0] + 2 + CPB * 3 && i < 100) begin
      tick(1);
      i++;
    end
    tx_en = 1'b0;
    wait_done(1, "mid_dis_wait");
    check_frame("mid_dis_line", 8'h5A, rd_log[0] + 2);
    push(8'h3C);
    tick(20);
    check("dis_hold", 32'(rd_log.size()), 32'(1));

    // Asynchronous reset during the third data bit of 8'h3C.
    rd_log.delete();
    done_log.delete();
    tx_en = 1'b1;
    wait_rd(1, "rst_wait");
    r = rd_log[0];
    i = 0;
    while (cyc < r + 15 && i < 100) begin
      tick(1);
      i++;
    end
    check("rst_pre_busy", 32'(busy), 32'(1));
    check("rst_pre_tx", 32'(tx), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx), 32'(1));
    check("rst_async_busy", 32'(busy), 32'(0));
    check("rst_async_done", 32'(done), 32'(0));
    tick(2);
    rst = 1'b0;
    rd_log.delete();
    done_log.delete();
    tick(20);
    check("post_rst_idle", 32'(rd_log.size()), 32'(0));
    tx_en = 1'b0;
    push(8'hC3);
    tick(10);
    check("post_rst_gated", 32'(rd_log.size()), 32'(0));
    t0 = cyc;
    tx_en = 1'b1;
    wait_rd(1, "post_rst_wait");
    check("post_rst_lat", 32'(rd_log[0] - t0), 32'(1));
    wait_done(1, "post_rst_done");

`ifdef FIFO_UART_TX_PARITY_EN
    // Even parity: 8'h07 -> 1, 8'h03 -> 0.
    rd_log.delete();
    done_log.delete();
    push(8'h07);
    wait_done(1, "par7_wait");
    r = rd_log[0];
    check("par7_bit", 32'(tx_hist[r + 2 + 9 * CPB + 1]), 32'(1));
    check("par7_frame", 32'(done_log[0] - (r + 2) + 1), 32'(44));
    push(8'h03);
    wait_done(2, "par3_wait");
    r = rd_log[1];
    check("par3_bit", 32'(tx_hist[r + 2 + 9 * CPB + 1]), 32'(0));
`endif

    // Randomized traffic, tx_en toggling and occasional async resets.
    for (int it = 0; it < 40; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act < 5 && (push_wr - pop_rd) < 4) begin
        push(8'($urandom));
      end else if (act < 8) begin
        tx_en = 1'($urandom_range(0, 1));
      end else if (act == 9) begin
        #($urandom_range(1, 3));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(1, 40));
    end

    // Drain whatever is left.
    tx_en = 1'b1;
    i = 0;
    while ((push_wr != pop_rd || busy) && i < 2000) begin
      tick(1);
      i++;
    end
    check("drain", 32'(push_wr == pop_rd && !busy), 32'(1));
    tick(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
